// File: rtl/activation_feeder_if.sv
// Load port and stream port of the activation feeder, grouped as one bundle.
// The master side feeds columns in and holds the stream; the slave side is the feeder.
interface activation_feeder_if #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] in_data;
  logic                    stall;
  logic [N*DATA_WIDTH-1:0] stream_out;
  logic                    stream_en;
  logic                    stream_first;
  logic                    stream_last;

  modport master (
    output in_valid, in_data, stall,
    input  in_ready, stream_out, stream_en, stream_first, stream_last
  );

  modport slave (
    input  in_valid, in_data, stall,
    output in_ready, stream_out, stream_en, stream_first, stream_last
  );
endinterface

// File: rtl/activation_feeder.sv
// Captures a tile of K column vectors, then replays it one column per cycle followed by
// FLUSH zero columns so the downstream skew buffer and array drain.
module activation_feeder #(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FLUSH      = 7,
  parameter int unsigned KW         = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KW-1:0]        cfg_k,
  activation_feeder_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 cfg_err
);

  localparam int unsigned W         = N * DATA_WIDTH;
  localparam int unsigned PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FW        = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam int unsigned FlushLast = (FLUSH > 0) ? FLUSH - 1 : 0;

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDrain} state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [PW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [FW-1:0]  fl_q, fl_d;
  logic [W-1:0]   out_q, out_d;
  logic           en_q, en_d, first_q, first_d, last_q, last_d;
  logic           done_q, done_d, err_q, err_d;
  logic           mem_we;
  logic           wr_last, rd_last;
  logic [W-1:0]   mem_q [DEPTH];

  assign wr_last = (KW'(wr_q) == k_q - KW'(1));
  assign rd_last = (KW'(rd_q) == k_q - KW'(1));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    fl_d    = fl_q;
    out_d   = out_q;
    en_d    = 1'b0;
    first_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_k != '0 && cfg_k <= KW'(DEPTH)) begin
            k_d     = cfg_k;
            wr_d    = '0;
            rd_d    = '0;
            fl_d    = '0;
            state_d = StLoad;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        if (bus.in_valid) begin
          mem_we = 1'b1;
          wr_d   = wr_q + PW'(1);
          if (wr_last) state_d = StStream;
        end
      end
      StStream: begin
        // A stalled cycle leaves out_q and the pointers untouched; only the strobes drop.
        if (!bus.stall) begin
          out_d   = mem_q[rd_q];
          en_d    = 1'b1;
          first_d = (rd_q == '0);
          last_d  = rd_last;
          rd_d    = rd_q + PW'(1);
          if (rd_last) begin
            if (FLUSH > 0) begin
              state_d = StDrain;
            end else begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
      end
      StDrain: begin
        if (!bus.stall) begin
          out_d = '0;
          en_d  = 1'b1;
          fl_d  = fl_q + FW'(1);
          if (fl_q == FW'(FlushLast)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      fl_q    <= '0;
      out_q   <= '0;
      en_q    <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      fl_q    <= fl_d;
      out_q   <= out_d;
      en_q    <= en_d;
      first_q <= first_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Tile storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_q] <= bus.in_data;
  end

  assign bus.in_ready     = (state_q == StLoad);
  assign bus.stream_out   = out_q;
  assign bus.stream_en    = en_q;
  assign bus.stream_first = first_q;
  assign bus.stream_last  = last_q;
  // The final beat lands as the FSM returns to idle, so hold busy through the done cycle.
  assign busy             = (state_q != StIdle) | done_q;
  assign done             = done_q;
  assign cfg_err          = err_q;

endmodule
